// File: rtl/jk_ctrl_pkg.sv
// Shared types for the JK latch bank controller: op codes, FSM states,
// requester count and a helper that says when the bank's J/K lines are driven.
package jk_ctrl_pkg;

   localparam int NUM_REQ = 2;

   typedef enum logic [1:0] {
      OP_HOLD   = 2'b00,
      OP_RESET  = 2'b01,
      OP_SET    = 2'b10,
      OP_TOGGLE = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_DONE
   } state_e;

   // J/K are presented from setup through hold so they bracket the enable pulse.
   function automatic logic drives_jk(input state_e s);
      return (s == ST_SETUP) || (s == ST_PULSE) || (s == ST_HOLD);
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The requester granted last becomes lowest
// priority once the grant is taken (adv_i). Requester 0 is favoured after reset.
module rr_arb2
   import jk_ctrl_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               adv_i,
   output logic [NUM_REQ-1:0] gnt_o
);

   // prio_q = 1 means requester 1 currently wins a tie
   logic prio_q, prio_d;

   // One-hot grant from the current priority, plus priority update on a taken grant
   always_comb begin
      gnt_o  = '0;
      prio_d = prio_q;
      if (prio_q) begin
         if (req_i[1])      gnt_o = 2'b10;
         else if (req_i[0]) gnt_o = 2'b01;
      end else begin
         if (req_i[0])      gnt_o = 2'b01;
         else if (req_i[1]) gnt_o = 2'b10;
      end
      if (adv_i && (gnt_o != '0)) prio_d = gnt_o[0];
   end

   // Priority pointer register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) prio_q <= 1'b0;
      else       prio_q <= prio_d;
   end

endmodule

// File: rtl/jk_latch_bank_ctrl.sv
// Shares a bank of WIDTH level-sensitive JK latches between two requesters.
// Each operation runs IDLE -> SETUP -> PULSE (PULSE_CYC) -> HOLD -> DONE.
// TOGGLE is resolved into per-bit SET/RESET from Q sampled at grant, so the
// transparent latches never see J=K=1.
// Optional feature: define JK_VERIFY_EN to compare the bank's Q against the
// requested result in DONE and flag a mismatch on err_o alongside ack_o.
module jk_latch_bank_ctrl
   import jk_ctrl_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int PULSE_CYC = 1
)(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [1:0]         op0_i,
   input  logic [WIDTH-1:0]   mask0_i,
   input  logic [1:0]         op1_i,
   input  logic [WIDTH-1:0]   mask1_i,
   output logic [NUM_REQ-1:0] ack_o,
   output logic               busy_o,
   output logic               err_o,
   input  logic [WIDTH-1:0]   q_in_i,
   output logic [WIDTH-1:0]   j_out_o,
   output logic [WIDTH-1:0]   k_out_o,
   output logic               c_out_o
);

   localparam int CW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(PULSE_CYC - 1);

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [NUM_REQ-1:0]   gnt, gnt_q, gnt_d;
   logic [WIDTH-1:0]     jop_q, jop_d, kop_q, kop_d;
   logic [WIDTH-1:0]     j_q, j_d, k_q, k_d;
   logic                 c_q, c_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic                 grant;
   op_e                  sel_op;
   logic [WIDTH-1:0]     sel_mask;

   assign grant    = (state_q == ST_IDLE) && (req_i != '0);
   assign sel_op   = gnt[1] ? op_e'(op1_i) : op_e'(op0_i);
   assign sel_mask = gnt[1] ? mask1_i : mask0_i;

   rr_arb2 u_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .req_i (req_i),
      .adv_i (grant),
      .gnt_o (gnt)
   );

   // Next state, operand capture at grant, and registered-output next values
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      jop_d   = jop_q;
      kop_d   = kop_q;
      unique case (state_q)
         ST_IDLE: begin
            if (grant) begin
               state_d = ST_SETUP;
               gnt_d   = gnt;
               unique case (sel_op)
                  OP_HOLD:   begin jop_d = '0;                  kop_d = '0;                 end
                  OP_RESET:  begin jop_d = '0;                  kop_d = sel_mask;           end
                  OP_SET:    begin jop_d = sel_mask;            kop_d = '0;                 end
                  OP_TOGGLE: begin jop_d = sel_mask & ~q_in_i;  kop_d = sel_mask & q_in_i;  end
                  default:   begin jop_d = '0;                  kop_d = '0;                 end
               endcase
            end
         end
         ST_SETUP: begin
            state_d = ST_PULSE;
            cnt_d   = '0;
         end
         ST_PULSE: begin
            if (cnt_q == CNT_LAST) state_d = ST_HOLD;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         ST_HOLD: state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Bank-facing outputs are registered from the next state so they are glitch-free
      j_d   = drives_jk(state_d) ? jop_d : '0;
      k_d   = drives_jk(state_d) ? kop_d : '0;
      c_d   = (state_d == ST_PULSE);
      ack_d = (state_d == ST_DONE) ? gnt_d : '0;
   end

   // State, operands and output registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         gnt_q   <= '0;
         jop_q   <= '0;
         kop_q   <= '0;
         j_q     <= '0;
         k_q     <= '0;
         c_q     <= 1'b0;
         ack_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         jop_q   <= jop_d;
         kop_q   <= kop_d;
         j_q     <= j_d;
         k_q     <= k_d;
         c_q     <= c_d;
         ack_q   <= ack_d;
      end
   end

   assign j_out_o = j_q;
   assign k_out_o = k_q;
   assign c_out_o = c_q;
   assign ack_o   = ack_q;
   assign busy_o  = (state_q != ST_IDLE);

`ifdef JK_VERIFY_EN
   op_e              op_q;
   logic [WIDTH-1:0] mask_q;
   logic             err_q, err_d;

   // Every masked non-HOLD bit has exactly one of J/K set, so the expected
   // Q under the mask is simply the J operand. Q is sampled on the last HOLD
   // cycle, after the enable has closed, so it reflects the settled bank.
   always_comb begin
      err_d = (state_q == ST_HOLD) && (op_q != OP_HOLD) &&
              (((q_in_i ^ jop_q) & mask_q) != '0);
   end

   // Op/mask capture for readback and the error flag register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         op_q   <= OP_HOLD;
         mask_q <= '0;
         err_q  <= 1'b0;
      end else begin
         if (grant) begin
            op_q   <= sel_op;
            mask_q <= sel_mask;
         end
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_jk_latch_bank_ctrl.sv
// Directed bench for jk_latch_bank_ctrl: reset, SET latency, TOGGLE resolution,
// HOLD, async reset mid-pulse, round-robin contention, readback error flag,
// early-dropped request, and a PULSE_CYC=3 instance for pulse/gap timing.
module tb_jk_latch_bank_ctrl;

   localparam logic EXP_ERR =
`ifdef JK_VERIFY_EN
      1'b1;
`else
      1'b0;
`endif

   logic       clk, rst;
   logic [1:0] req, op0, op1, ack;
   logic [7:0] mask0, mask1, q_in, j, k;
   logic       busy, err, c;

   logic [1:0] req3, ack3;
   logic [7:0] q3, j3, k3;
   logic       busy3, err3, c3;

   int n_chk  = 0;
   int n_fail = 0;

   jk_latch_bank_ctrl #(.WIDTH(8), .PULSE_CYC(1)) u0 (
      .clk_i(clk), .rst_i(rst), .req_i(req),
      .op0_i(op0), .mask0_i(mask0), .op1_i(op1), .mask1_i(mask1),
      .ack_o(ack), .busy_o(busy), .err_o(err),
      .q_in_i(q_in), .j_out_o(j), .k_out_o(k), .c_out_o(c)
   );

   jk_latch_bank_ctrl #(.WIDTH(8), .PULSE_CYC(3)) u3 (
      .clk_i(clk), .rst_i(rst), .req_i(req3),
      .op0_i(2'b10), .mask0_i(8'h01), .op1_i(2'b00), .mask1_i(8'h00),
      .ack_o(ack3), .busy_o(busy3), .err_o(err3),
      .q_in_i(q3), .j_out_o(j3), .k_out_o(k3), .c_out_o(c3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Bounded wait for the next ack pulse; a timeout shows up as ack=0 vs expected
   task automatic wait_ack(input logic [1:0] exp, input string tag);
      int n = 0;
      do begin
         tick();
         n++;
      end while (ack == 2'b00 && n < 12);
      check(tag, {30'd0, ack}, {30'd0, exp});
   endtask

   initial begin
      logic        ack_seen;
      logic        cv [40];
      int          edges[$];

      rst = 1'b1; req = '0; op0 = '0; op1 = '0; mask0 = '0; mask1 = '0; q_in = '0;
      req3 = '0; q3 = 8'h01;
      tick(); tick();
      check("rst_j",    {24'd0, j}, 32'h00);
      check("rst_k",    {24'd0, k}, 32'h00);
      check("rst_c",    {31'd0, c}, 32'h0);
      check("rst_ack",  {30'd0, ack}, 32'h0);
      check("rst_busy", {31'd0, busy}, 32'h0);
      check("rst_err",  {31'd0, err}, 32'h0);
      check("u3_rst",   {10'd0, ack3, busy3, err3, c3, j3, k3}, 32'h0);
      rst = 1'b0;
      tick();

      // SET mask 0F from requester 0: latency and line sequence
      req = 2'b01; op0 = 2'b10; mask0 = 8'h0F;
      tick();
      check("set_setup_j", {24'd0, j}, 32'h0F);
      check("set_setup_c", {31'd0, c}, 32'h0);
      check("set_busy",    {31'd0, busy}, 32'h1);
      tick();
      check("set_pulse_c", {31'd0, c}, 32'h1);
      check("set_pulse_jk", {16'd0, j, k}, 32'h0F00);
      q_in = 8'h0F;
      tick();
      check("set_hold_c",  {31'd0, c}, 32'h0);
      check("set_hold_j",  {24'd0, j}, 32'h0F);
      tick();
      check("set_ack",     {30'd0, ack}, 32'h1);
      check("set_done_jk", {16'd0, j, k}, 32'h0);
      check("set_err",     {31'd0, err}, 32'h0);
      req = 2'b00;
      tick();
      check("set_ack_gone", {30'd0, ack, busy}, 32'h0);

      // TOGGLE all bits of A5 from requester 1; Q change after grant must not matter
      q_in = 8'hA5; req = 2'b10; op1 = 2'b11; mask1 = 8'hFF;
      tick();
      check("tog_setup_jk", {16'd0, j, k}, 32'h5AA5);
      check("tog_overlap",  {24'd0, j & k}, 32'h0);
      q_in = 8'h5A;
      tick();
      check("tog_pulse", {15'd0, c, j, k}, 32'h15AA5);
      wait_ack(2'b10, "tog_ack");
      check("tog_err", {31'd0, err}, 32'h0);
      req = 2'b00;
      tick();

      // HOLD never drives J/K and never flags an error
      q_in = 8'h33; req = 2'b01; op0 = 2'b00; mask0 = 8'hFF;
      tick();
      check("hold_jk", {16'd0, j, k}, 32'h0);
      wait_ack(2'b01, "hold_ack");
      check("hold_err", {31'd0, err}, 32'h0);
      req = 2'b00;
      tick();

      // Async reset in the middle of the pulse
      req = 2'b01; op0 = 2'b10; mask0 = 8'hFF;
      tick(); tick();
      check("mid_pulse_c", {31'd0, c}, 32'h1);
      #2 rst = 1'b1; req = 2'b00;
      #1 check("mid_rst_drop", {13'd0, c, j, k, ack, busy}, 32'h0);
      tick(); tick();
      rst = 1'b0;
      ack_seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         ack_seen = ack_seen | (ack != 2'b00);
      end
      check("mid_no_ack", {30'd0, ack_seen, busy}, 32'h0);

      // Contention from reset: grants alternate 0,1,0,1, each ack one cycle
      op0 = 2'b10; mask0 = 8'h01; op1 = 2'b01; mask1 = 8'h02; q_in = 8'h01;
      req = 2'b11;
      for (int n = 0; n < 4; n++) begin
         wait_ack((n % 2 == 0) ? 2'b01 : 2'b10, "rr_ack");
         check("rr_err", {31'd0, err}, 32'h0);
         tick();
         check("rr_ack_1cyc", {30'd0, ack}, 32'h0);
      end
      req = 2'b00;
      tick();

      // Readback mismatch: SET bit 0 while the bank keeps Q[0]=0
      q_in = 8'h00; req = 2'b01; op0 = 2'b10; mask0 = 8'h01;
      wait_ack(2'b01, "vfy_ack");
      check("vfy_err", {31'd0, err}, {31'd0, EXP_ERR});
      req = 2'b00;
      tick();
      check("vfy_err_clr", {31'd0, err}, 32'h0);

      // Request dropped after one cycle still completes
      req = 2'b01; op0 = 2'b01; mask0 = 8'hF0;
      tick();
      req = 2'b00;
      check("drop_jk", {16'd0, j, k}, 32'h00F0);
      wait_ack(2'b01, "drop_ack");
      tick();
      check("drop_idle", {30'd0, ack, busy}, 32'h0);

      // PULSE_CYC=3: pulse width and low gap between back-to-back ops
      req3 = 2'b01;
      for (int i = 0; i < 40; i++) begin
         tick();
         cv[i] = c3;
      end
      req3 = 2'b00;
      for (int i = 1; i < 40; i++)
         if (cv[i] != cv[i-1]) edges.push_back(i);
      check("pc3_edges", {31'd0, edges.size() >= 4}, 32'h1);
      if (edges.size() >= 4) begin
         check("pc3_hi1", edges[1] - edges[0], 32'd3);
         check("pc3_gap", edges[2] - edges[1], 32'd4);
         check("pc3_hi2", edges[3] - edges[2], 32'd3);
      end
      check("pc3_jk", {24'd0, j3 & k3}, 32'h0);
      check("pc3_err", {31'd0, err3}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
